// File: rtl/mem_resp_pkg.sv
// Shared types, derived line geometry and the power-up line pattern for the
// main-memory responder.
package mem_resp_pkg;

   localparam int unsigned DEF_ADDR_WIDTH       = 16;
   localparam int unsigned DEF_DATA_WIDTH       = 8;
   localparam int unsigned DEF_CACHE_WORD_WIDTH = 32;

   localparam int unsigned BYTES_PER_LINE = DEF_CACHE_WORD_WIDTH / DEF_DATA_WIDTH;
   localparam int unsigned OFFSET_BITS    = $clog2(BYTES_PER_LINE);
   localparam int unsigned NUM_LINES      = 2 ** (DEF_ADDR_WIDTH - OFFSET_BITS);

   // Widest line the init pattern can describe; callers truncate to their width.
   localparam int unsigned INIT_MAX_W = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } mem_state_t;

   // Byte k of line L holds (L*bytes + k) mod 2**byte_w, byte 0 in the LSBs.
   function automatic logic [INIT_MAX_W-1:0] init_line(
      input int unsigned line,
      input int unsigned n_bytes = BYTES_PER_LINE,
      input int unsigned byte_w  = DEF_DATA_WIDTH
   );
      logic [INIT_MAX_W-1:0] v;
      int unsigned           b;
      v = '0;
      for (int unsigned k = 0; k < n_bytes; k++) begin
         b = (line * n_bytes + k) & ((32'd1 << byte_w) - 32'd1);
         v = v | (INIT_MAX_W'(b) << (k * byte_w));
      end
      return v;
   endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache-to-main-memory line-fill / write-back bus.
interface main_mem_responder_if #(
   parameter int unsigned ADDR_WIDTH       = 16,
   parameter int unsigned CACHE_WORD_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]       addr_main;
   logic                        addr_main_en;
   logic                        main_is_rd;
   logic [CACHE_WORD_WIDTH-1:0] wr_data_main;
   logic [CACHE_WORD_WIDTH-1:0] rd_data_main;
   logic                        data_main_vld;
   logic                        mem_busy;
   logic                        req_dropped;

   modport master (
      output addr_main, addr_main_en, main_is_rd, wr_data_main,
      input  rd_data_main, data_main_vld, mem_busy, req_dropped
   );

   modport slave (
      input  addr_main, addr_main_en, main_is_rd, wr_data_main,
      output rd_data_main, data_main_vld, mem_busy, req_dropped
   );
endinterface

// File: rtl/line_ram.sv
// Single-port line storage: synchronous write, combinational read, contents
// preset to the init_line pattern and never cleared by reset.
module line_ram
   import mem_resp_pkg::*;
#(
   parameter int unsigned IDX_W  = DEF_ADDR_WIDTH - OFFSET_BITS,
   parameter int unsigned LINE_W = DEF_CACHE_WORD_WIDTH,
   parameter int unsigned BYTE_W = DEF_DATA_WIDTH
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [LINE_W-1:0] wr_line,
   output logic [LINE_W-1:0] rd_line_c
);
   localparam int unsigned DEPTH = 2 ** IDX_W;

   typedef logic [LINE_W-1:0] mem_t [DEPTH];

   function automatic mem_t init_mem();
      mem_t m;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         m[i] = LINE_W'(init_line(i, LINE_W / BYTE_W, BYTE_W));
      end
      return m;
   endfunction

   mem_t mem = init_mem();

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wr_line;
      end
   end

   assign rd_line_c = mem[idx];

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: accepts one line read/write at a time and completes
// it after a fixed latency with a one-cycle valid pulse.
module main_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int unsigned CACHE_WORD_WIDTH = DEF_CACHE_WORD_WIDTH,
   parameter int unsigned READ_LATENCY     = 2,
   parameter int unsigned WRITE_LATENCY    = 2
) (
   input  logic               clk,
   input  logic               flush,
   main_mem_responder_if.slave bus
);
   localparam int unsigned LINE_BYTES = CACHE_WORD_WIDTH / DATA_WIDTH;
   localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
   localparam int unsigned IDX_W      = ADDR_WIDTH - OFF_W;
   localparam int unsigned MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                       : WRITE_LATENCY;
   localparam int unsigned CNT_W      = $clog2(MAX_LAT + 1);

   mem_state_t                  state;
   logic [CNT_W-1:0]            cnt;
   logic [IDX_W-1:0]            idx_q;
   logic [CACHE_WORD_WIDTH-1:0] wr_line_q;
   logic [CACHE_WORD_WIDTH-1:0] rd_data_q;
   logic                        vld_q;
   logic                        busy_q;
   logic                        dropped_q;

   logic                        done_c;
   logic                        ram_we_c;
   logic [CACHE_WORD_WIDTH-1:0] ram_rd_c;
   logic                        unused_off;

   // Counter reaching 1 marks the completing edge E_LAT.
   assign done_c   = (state != IDLE) && (cnt == CNT_W'(1));
   assign ram_we_c = (state == WR_WAIT) && done_c && !flush;

   assign unused_off = ^bus.addr_main[OFF_W-1:0];

   line_ram #(
      .IDX_W  (IDX_W),
      .LINE_W (CACHE_WORD_WIDTH),
      .BYTE_W (DATA_WIDTH)
   ) u_line_ram (
      .clk       (clk),
      .we        (ram_we_c),
      .idx       (idx_q),
      .wr_line   (wr_line_q),
      .rd_line_c (ram_rd_c)
   );

   always_ff @(posedge clk) begin
      if (flush) begin
         state     <= IDLE;
         cnt       <= '0;
         idx_q     <= '0;
         wr_line_q <= '0;
         rd_data_q <= '0;
         vld_q     <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.addr_main_en) begin
                  idx_q     <= bus.addr_main[ADDR_WIDTH-1:OFF_W];
                  wr_line_q <= bus.wr_data_main;
                  busy_q    <= 1'b1;
                  if (bus.main_is_rd) begin
                     state <= RD_WAIT;
                     cnt   <= CNT_W'(READ_LATENCY);
                  end else begin
                     state <= WR_WAIT;
                     cnt   <= CNT_W'(WRITE_LATENCY);
                  end
               end
            end
            RD_WAIT, WR_WAIT: begin
               // Requests seen while busy (including at E_LAT) are dropped.
               if (bus.addr_main_en) begin
                  dropped_q <= 1'b1;
               end
               if (done_c) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  vld_q  <= 1'b1;
                  cnt    <= '0;
                  if (state == RD_WAIT) begin
                     rd_data_q <= ram_rd_c;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_data_main  = rd_data_q;
   assign bus.data_main_vld = vld_q;
   assign bus.mem_busy      = busy_q;
   assign bus.req_dropped   = dropped_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder at default parameters.
module tb_main_mem_responder;

   logic clk;
   logic flush;
   int   checks;
   int   errors;

   main_mem_responder_if #(.ADDR_WIDTH(16), .CACHE_WORD_WIDTH(32)) bus ();

   main_mem_responder #(
      .ADDR_WIDTH       (16),
      .DATA_WIDTH       (8),
      .CACHE_WORD_WIDTH (32),
      .READ_LATENCY     (2),
      .WRITE_LATENCY    (2)
   ) dut (
      .clk   (clk),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and observe the six cycles after its acceptance edge.
   task automatic run_req(input logic [15:0] a, input logic rd, input logic [31:0] wd,
                          output int busy_cnt, output int vld_at, output int vld_cnt,
                          output logic [31:0] line);
      bus.addr_main    = a;
      bus.main_is_rd   = rd;
      bus.wr_data_main = wd;
      bus.addr_main_en = 1'b1;
      tick();
      bus.addr_main_en = 1'b0;
      busy_cnt = 0;
      vld_at   = -1;
      vld_cnt  = 0;
      line     = '0;
      for (int i = 0; i < 6; i++) begin
         if (bus.mem_busy) busy_cnt++;
         if (bus.data_main_vld) begin
            vld_cnt++;
            if (vld_at < 0) vld_at = i;
            line = bus.rd_data_main;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      bus.addr_main    = 16'h0104;
      bus.main_is_rd   = 1'b1;
      bus.wr_data_main = '0;
      bus.addr_main_en = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.addr_main_en = 1'b0;
      checks += 4;
      if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.mem_busy); end
      if (bus.data_main_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.data_main_vld); end
      if (bus.rd_data_main !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 00000000", bus.rd_data_main); end
      if (bus.req_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", bus.req_dropped); end
      tick();
      checks++;
      if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL flush_wins_accept: busy got %b want 0", bus.mem_busy); end
   endtask

   task automatic test_read();
      int bc, va, vc;
      logic [31:0] ln;
      run_req(16'h0104, 1'b1, 32'h0, bc, va, vc, ln);
      checks += 5;
      if (bc !== 2) begin errors++; $display("FAIL read_busy_cycles: got %0d want 2", bc); end
      if (va !== 2) begin errors++; $display("FAIL read_vld_cycle: got %0d want 2", va); end
      if (vc !== 1) begin errors++; $display("FAIL read_vld_count: got %0d want 1", vc); end
      if (ln !== 32'h07060504) begin errors++; $display("FAIL read_0104: got %h want 07060504", ln); end
      if (bus.rd_data_main !== 32'h07060504) begin errors++; $display("FAIL read_hold: got %h want 07060504", bus.rd_data_main); end
   endtask

   task automatic test_write_read();
      int bc, va, vc;
      logic [31:0] ln;
      run_req(16'h0104, 1'b0, 32'hDEADBEEF, bc, va, vc, ln);
      checks += 3;
      if (bc !== 2) begin errors++; $display("FAIL write_busy_cycles: got %0d want 2", bc); end
      if (va !== 2) begin errors++; $display("FAIL write_vld_cycle: got %0d want 2", va); end
      if (vc !== 1) begin errors++; $display("FAIL write_vld_count: got %0d want 1", vc); end
      run_req(16'h0106, 1'b1, 32'h0, bc, va, vc, ln);
      checks++;
      if (ln !== 32'hDEADBEEF) begin errors++; $display("FAIL read_after_write_0106: got %h want deadbeef", ln); end
      run_req(16'h0108, 1'b1, 32'h0, bc, va, vc, ln);
      checks++;
      if (ln !== 32'h0B0A0908) begin errors++; $display("FAIL read_neighbour_0108: got %h want 0b0a0908", ln); end
   endtask

   task automatic test_drop();
      int vc;
      bus.addr_main    = 16'h0000;
      bus.main_is_rd   = 1'b1;
      bus.addr_main_en = 1'b1;
      tick();
      bus.addr_main = 16'h0040;
      tick();
      bus.addr_main_en = 1'b0;
      checks += 2;
      if (bus.req_dropped !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b want 1", bus.req_dropped); end
      if (bus.mem_busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", bus.mem_busy); end
      tick();
      checks += 2;
      if (bus.data_main_vld !== 1'b1) begin errors++; $display("FAIL drop_first_vld: got %b want 1", bus.data_main_vld); end
      if (bus.rd_data_main !== 32'h03020100) begin errors++; $display("FAIL drop_first_data: got %h want 03020100", bus.rd_data_main); end
      vc = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.data_main_vld) vc++;
      end
      checks += 2;
      if (vc !== 0) begin errors++; $display("FAIL drop_no_second_vld: got %0d want 0", vc); end
      if (bus.req_dropped !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", bus.req_dropped); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks += 2;
      if (bus.req_dropped !== 1'b0) begin errors++; $display("FAIL drop_cleared: got %b want 0", bus.req_dropped); end
      if (bus.rd_data_main !== 32'h0) begin errors++; $display("FAIL flush_clears_rd: got %h want 00000000", bus.rd_data_main); end
   endtask

   task automatic test_flush_abort();
      int bc, va, vc;
      logic [31:0] ln;
      bus.addr_main    = 16'h0200;
      bus.main_is_rd   = 1'b0;
      bus.wr_data_main = 32'h12345678;
      bus.addr_main_en = 1'b1;
      tick();
      bus.addr_main_en = 1'b0;
      checks++;
      if (bus.mem_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", bus.mem_busy); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vc = 0;
      checks++;
      if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", bus.mem_busy); end
      for (int i = 0; i < 4; i++) begin
         if (bus.data_main_vld) vc++;
         tick();
      end
      checks++;
      if (vc !== 0) begin errors++; $display("FAIL abort_no_vld: got %0d want 0", vc); end
      run_req(16'h0200, 1'b1, 32'h0, bc, va, vc, ln);
      checks += 2;
      if (vc !== 1) begin errors++; $display("FAIL abort_read_vld: got %0d want 1", vc); end
      if (ln !== 32'h03020100) begin errors++; $display("FAIL abort_not_committed: got %h want 03020100", ln); end
   endtask

   task automatic test_back_to_back();
      checks++;
      if (bus.req_dropped !== 1'b0) begin errors++; $display("FAIL b2b_dropped_start: got %b want 0", bus.req_dropped); end
      bus.addr_main    = 16'h0010;
      bus.main_is_rd   = 1'b1;
      bus.addr_main_en = 1'b1;
      tick();                                   // E0
      bus.addr_main_en = 1'b0;
      tick();                                   // E1
      bus.addr_main    = 16'h0020;
      bus.addr_main_en = 1'b1;
      tick();                                   // E2: dropped
      checks += 3;
      if (bus.data_main_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld_e2: got %b want 1", bus.data_main_vld); end
      if (bus.rd_data_main !== 32'h13121110) begin errors++; $display("FAIL b2b_data_a: got %h want 13121110", bus.rd_data_main); end
      if (bus.req_dropped !== 1'b1) begin errors++; $display("FAIL b2b_drop_e2: got %b want 1", bus.req_dropped); end
      bus.addr_main = 16'h0030;
      tick();                                   // E3: accepted
      bus.addr_main_en = 1'b0;
      checks += 2;
      if (bus.mem_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e3: got %b want 1", bus.mem_busy); end
      if (bus.data_main_vld !== 1'b0) begin errors++; $display("FAIL b2b_vld_e3: got %b want 0", bus.data_main_vld); end
      tick();                                   // E4
      checks++;
      if (bus.mem_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e4: got %b want 1", bus.mem_busy); end
      tick();                                   // E5
      checks += 3;
      if (bus.data_main_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld_e5: got %b want 1", bus.data_main_vld); end
      if (bus.rd_data_main !== 32'h33323130) begin errors++; $display("FAIL b2b_data_b: got %h want 33323130", bus.rd_data_main); end
      if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_e5: got %b want 0", bus.mem_busy); end
      tick();
   endtask

   task automatic test_top_line();
      int bc, va, vc;
      logic [31:0] ln;
      run_req(16'hFFFF, 1'b1, 32'h0, bc, va, vc, ln);
      checks++;
      if (ln !== 32'hFFFEFDFC) begin errors++; $display("FAIL top_line_read: got %h want fffefdfc", ln); end
      run_req(16'hFFFC, 1'b0, 32'hA5A5A5A5, bc, va, vc, ln);
      checks++;
      if (vc !== 1) begin errors++; $display("FAIL top_line_write_vld: got %0d want 1", vc); end
      run_req(16'hFFFC, 1'b1, 32'h0, bc, va, vc, ln);
      checks++;
      if (ln !== 32'hA5A5A5A5) begin errors++; $display("FAIL top_line_readback: got %h want a5a5a5a5", ln); end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      flush            = 1'b1;
      bus.addr_main    = '0;
      bus.addr_main_en = 1'b0;
      bus.main_is_rd   = 1'b0;
      bus.wr_data_main = '0;
      tick();
      test_reset();
      test_read();
      test_write_read();
      test_drop();
      test_flush_abort();
      test_back_to_back();
      test_top_line();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Memory-side responder for the direct-mapped cache's line-fill/write-back interface. It owns the main-memory line storage and answers one cache request at a time. Reads return the full cache line and writes commit it, each with a fixed, parameterised latency. It replaces the behavioural DRAM model as the synthesizable far end of the cache's `addr_main` protocol.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: byte address width.
- `DATA_WIDTH`, 8: CPU byte width.
- `CACHE_WORD_WIDTH`, 32: line width; one line is transferred per request.
- `READ_LATENCY`, 2: busy cycles before read data is returned. Must be ≥1.
- `WRITE_LATENCY`, 2: busy cycles before a write is committed. Must be ≥1.

Ports:
- `clk`, in, 1: single clock. Everything is on its rising edge.
- `flush`, in, 1: reset. Synchronous, active-high.
- `addr_main`, in, `ADDR_WIDTH`: byte address of the request.
- `addr_main_en`, in, 1: request strobe, sampled each edge.
- `main_is_rd`, in, 1: 1 = line fill (read), 0 = write-back.
- `wr_data_main`, in, `CACHE_WORD_WIDTH`: write-back line, sampled at acceptance.
- `rd_data_main`, out, `CACHE_WORD_WIDTH`: read line. Holds its value between responses.
- `data_main_vld`, out, 1: one-cycle completion pulse, for both reads and writes.
- `mem_busy`, out, 1: a request is in flight.
- `req_dropped`, out, 1: sticky flag; a request arrived while busy.

## Operation
- `OFFSET_BITS = log2(CACHE_WORD_WIDTH/DATA_WIDTH)`. This is 2 at the default parameters.
- Line index is `addr_main[ADDR_WIDTH-1:OFFSET_BITS]`. Offset bits are ignored.
- The array holds `2**(ADDR_WIDTH-OFFSET_BITS)` lines.
- Power-up contents: byte k of line L = `(L*BYTES_PER_LINE + k)` mod `2**DATA_WIDTH`. Byte 0 is in the LSBs.
- `flush` does not alter array contents.
- FSM states:
  - `IDLE`. On `addr_main_en`, latch the request and go to `RD_WAIT` or `WR_WAIT`.
  - `RD_WAIT`. Count down `READ_LATENCY`. At expiry, load `rd_data_main` from the array, pulse `data_main_vld`, and return to `IDLE`.
  - `WR_WAIT`. Count down `WRITE_LATENCY`. At expiry, write the latched line to the array, pulse `data_main_vld`, and return to `IDLE`.
- `addr_main_en` while `mem_busy`=1: the request is ignored and `req_dropped` is set. It stays set until `flush`.
- The counter is sized to max(`READ_LATENCY`, `WRITE_LATENCY`). It never wraps.

## Timing
- Acceptance edge E0: the edge where `addr_main_en`=1, `mem_busy`=0 and `flush`=0.
- Address, `main_is_rd` and `wr_data_main` are captured at E0.
- Latency is LAT = `READ_LATENCY` or `WRITE_LATENCY`.
- `mem_busy`=1 in the LAT cycles following E0. It is 0 after edge E_LAT.
- `data_main_vld`=1 for exactly the one cycle following E_LAT.
- For reads, `rd_data_main` is valid in that same cycle.
- For writes, the array update takes effect at E_LAT.
- The next request can be accepted at E_LAT+1. Turnaround is LAT+1 cycles.
- A read issued after a write completes to the same line returns the new data.
- Reset values after a `flush` edge: `mem_busy`=0, `data_main_vld`=0, `rd_data_main`=0, `req_dropped`=0, state=`IDLE`.
- `flush` mid-operation: the request is aborted, the write is not committed, and no `data_main_vld` is produced.
- `flush` together with `addr_main_en` on the same edge: `flush` wins and the request is not accepted.
- Request on the same edge that `mem_busy` falls (E_LAT): `mem_busy` was still 1 in the sampled cycle, so the request is dropped and `req_dropped` is set.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum `mem_state_t`;
  - the derived constants `BYTES_PER_LINE`, `OFFSET_BITS`, `NUM_LINES`;
  - the init-pattern function `init_line(L)`.
- Sub-module `line_ram`: single-port array with synchronous write and combinational read. It is initialised from `init_line`.
- The top level holds the FSM, the latency counter, the request latches and the flags.

## Test plan
- `flush`, then read `0x0104` → `mem_busy` high for 2 cycles, then `data_main_vld` pulse with `rd_data_main`=`0x07060504`.
- Write `0x0104` with `0xDEADBEEF`, then read `0x0106` → `0xDEADBEEF` (offset ignored). A neighbouring read of `0x0108` → `0x0B0A0908`.
- Read accepted at E0; second request at E1 → no second response, `req_dropped`=1. After `flush`, `req_dropped`=0.
- `flush` asserted while a write of `0x12345678` to `0x0200` is in `WR_WAIT` → no `vld`. A subsequent read of `0x0200` → `0x03020100`.
- Back-to-back reads accepted at E0 and E3 (LAT=2) → `vld` after E2 and after E5. Request at E2 → dropped.
- Top line: read `0xFFFF` → `0xFFFEFDFC`. Write then read `0xFFFC` with `0xA5A5A5A5` → `0xA5A5A5A5`.
